// File: rtl/inverse_zigzag_pkg.sv
// Shared JPEG constants for the inverse zigzag block: coefficient width default,
// block dimension and the raster-to-scan-position table.
package inverse_zigzag_pkg;

    localparam int unsigned BW_DEFAULT = 8;
    localparam int unsigned BLK_DIM    = 8;
    localparam int unsigned BLK_SIZE   = BLK_DIM * BLK_DIM;

    // Entry [8*row + col] is the zigzag scan position of raster coefficient (row, col).
    localparam int unsigned ZZ_POS [BLK_SIZE] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    function automatic logic [5:0] zz_pos(input logic [2:0] row, input logic [2:0] col);
        return 6'(ZZ_POS[{row, col}]);
    endfunction

endpackage

// File: rtl/coeff_bank.sv
// One 64-coefficient bank: eight coefficients written per beat, whole block read flat.
// Flat read layout: scan position p occupies o_coeffs[p*BW +: BW].
module coeff_bank
    import inverse_zigzag_pkg::*;
#(
    parameter int unsigned BW = BW_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [2:0]             i_beat,
    input  logic [BLK_DIM*BW-1:0]  i_data,
    output logic [BLK_SIZE*BW-1:0] o_coeffs
);

    logic [BW-1:0] mem_q [BLK_SIZE];

    // MSB lane of a beat carries the lowest scan position of that beat.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                mem_q[{i_beat, 3'(c)}] <= i_data[(BLK_DIM-1-c)*BW +: BW];
            end
        end
    end

    for (genvar p = 0; p < BLK_SIZE; p++) begin : g_flat
        assign o_coeffs[p*BW +: BW] = mem_q[p];
    end

endmodule

// File: rtl/inverse_zigzag.sv
// Ping-pong inverse zigzag: accepts eight zigzag-ordered beats per block and emits
// the block as eight raster rows, column 0 in the MSB lane.
module inverse_zigzag
    import inverse_zigzag_pkg::*;
#(
    parameter int unsigned BW = BW_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_Reset,
    input  logic [BLK_DIM*BW-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [BLK_DIM*BW-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    logic [2:0] wr_cnt_q, wr_cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_cnt_q, rd_cnt_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] full_q, full_d;

    logic                   in_fire;
    logic                   out_fire;
    logic [1:0]             bank_we;
    logic [BLK_SIZE*BW-1:0] bank0_flat;
    logic [BLK_SIZE*BW-1:0] bank1_flat;
    logic [BLK_SIZE*BW-1:0] rd_flat;

    assign o_ready  = ~full_q[wr_ptr_q];
    assign o_valid  = full_q[rd_ptr_q];
    assign o_last   = o_valid & (rd_cnt_q == 3'd7);
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign bank_we  = {in_fire & wr_ptr_q, in_fire & ~wr_ptr_q};
    assign rd_flat  = rd_ptr_q ? bank1_flat : bank0_flat;

    coeff_bank #(
        .BW (BW)
    ) u_bank0 (
        .i_clk    (i_clk),
        .i_we     (bank_we[0]),
        .i_beat   (wr_cnt_q),
        .i_data   (i_data),
        .o_coeffs (bank0_flat)
    );

    coeff_bank #(
        .BW (BW)
    ) u_bank1 (
        .i_clk    (i_clk),
        .i_we     (bank_we[1]),
        .i_beat   (wr_cnt_q),
        .i_data   (i_data),
        .o_coeffs (bank1_flat)
    );

    // Set and clear never target the same bank: a write bank that is also the
    // read bank must be empty, so it cannot be presenting a row.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_cnt_d = rd_cnt_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end
        end
        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
            if (rd_cnt_q == 3'd7) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_cnt_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_cnt_q <= '0;
            rd_ptr_q <= 1'b0;
            full_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_cnt_q <= rd_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
        end
    end

    always_comb begin
        o_data = '0;
        if (o_valid) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                o_data[(BLK_DIM-1-c)*BW +: BW] = rd_flat[zz_pos(rd_cnt_q, 3'(c))*BW +: BW];
            end
        end
    end

endmodule
